// File: rtl/osc_pkg.sv
// Shared constants, FSM state type and derived datapath widths for the
// ADC mean-square accumulator feeding the RMS stage.
package osc_pkg;

  localparam int ADC_W_DEF    = 8;
  localparam int LOG2_N_DEF   = 10;
  localparam int MID_CODE_DEF = 128;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACCUM,
    ST_DRAIN,
    ST_HOLD
  } state_t;

  // |c| never exceeds 2^(ADC_W-1), so its square fits in 2*ADC_W-1 bits.
  function automatic int sq_width(input int adc_w);
    return 2 * adc_w - 1;
  endfunction

  function automatic int acc_width(input int adc_w, input int log2_n);
    return sq_width(adc_w) + log2_n;
  endfunction

endpackage

// File: rtl/vrms_sq_accum_sq_pipe.sv
// Two-stage centre-and-square pipeline: removes the mid-code offset, then
// squares the signed result. Valid bits travel with the data.
module sq_pipe
  import osc_pkg::*;
#(
  parameter int ADC_W    = ADC_W_DEF,
  parameter int MID_CODE = MID_CODE_DEF
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [ADC_W-1:0]            i_data,
  input  logic                        i_valid,
  output logic [sq_width(ADC_W)-1:0]  o_sq_p2,
  output logic                        o_vld_p1,
  output logic                        o_vld_p2
);

  localparam int SQ_W = sq_width(ADC_W);
  localparam logic signed [ADC_W:0] MID_S = (ADC_W+1)'(MID_CODE);

  logic signed [ADC_W:0] r_c_p1;
  logic                  r_vld_p1;
  logic [SQ_W-1:0]       r_sq_p2;
  logic                  r_vld_p2;

  function automatic logic signed [ADC_W:0] centre(input logic [ADC_W-1:0] x);
    return $signed({1'b0, x}) - MID_S;
  endfunction

  // Square via the magnitude so the product stays in SQ_W bits.
  function automatic logic [SQ_W-1:0] square(input logic signed [ADC_W:0] c);
    logic [SQ_W-1:0] m;
    m = c[ADC_W] ? SQ_W'(-c) : SQ_W'(c);
    return m * m;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_vld_p1 <= 1'b0;
      r_vld_p2 <= 1'b0;
    end else begin
      r_vld_p1 <= i_valid;
      r_vld_p2 <= r_vld_p1;
    end
  end

  // p0 -> p1: centre; p1 -> p2: square
  always_ff @(posedge clk) begin
    if (i_valid) begin
      r_c_p1 <= centre(i_data);
    end
    if (r_vld_p1) begin
      r_sq_p2 <= square(r_c_p1);
    end
  end

  assign o_sq_p2  = r_sq_p2;
  assign o_vld_p1 = r_vld_p1;
  assign o_vld_p2 = r_vld_p2;

endmodule

// File: rtl/vrms_sq_accum.sv
// Accumulates squared, offset-removed ADC samples over 2^LOG2_N accepted
// samples and hands the floor mean square downstream over valid/ready.
module vrms_sq_accum
  import osc_pkg::*;
#(
  parameter int ADC_W    = ADC_W_DEF,
  parameter int LOG2_N   = LOG2_N_DEF,
  parameter int MID_CODE = MID_CODE_DEF
) (
  input  logic                        sys_clk,
  input  logic                        rst,
  input  logic [ADC_W-1:0]            adc_data,
  input  logic                        adc_valid,
  input  logic                        start,
  input  logic                        cont,
  output logic                        busy,
  output logic [sq_width(ADC_W)-1:0]  ms_data,
  output logic                        ms_valid,
  input  logic                        ms_ready,
  output logic                        overrun
);

  localparam int SQ_W  = sq_width(ADC_W);
  localparam int ACC_W = acc_width(ADC_W, LOG2_N);

  state_t             r_state;
  logic [ACC_W-1:0]   r_acc;
  logic [LOG2_N-1:0]  r_cnt;
  logic               r_busy;
  logic [SQ_W-1:0]    r_ms_data;
  logic               r_ms_valid;
  logic               r_overrun;

  logic               w_launch;
  logic               w_vld_p1;
  logic               w_vld_p2;
  logic [SQ_W-1:0]    w_sq_p2;
  logic [ACC_W-1:0]   w_acc_next;

  function automatic logic [SQ_W-1:0] mean_floor(input logic [ACC_W-1:0] acc);
    return acc[ACC_W-1:LOG2_N];
  endfunction

  assign w_launch   = (r_state == ST_ACCUM) && adc_valid;
  assign w_acc_next = r_acc + (w_vld_p2 ? ACC_W'(w_sq_p2) : '0);

  sq_pipe #(
    .ADC_W    (ADC_W),
    .MID_CODE (MID_CODE)
  ) u_sq_pipe (
    .clk      (sys_clk),
    .rst      (rst),
    .i_data   (adc_data),
    .i_valid  (w_launch),
    .o_sq_p2  (w_sq_p2),
    .o_vld_p1 (w_vld_p1),
    .o_vld_p2 (w_vld_p2)
  );

  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_acc      <= '0;
      r_cnt      <= '0;
      r_busy     <= 1'b0;
      r_ms_data  <= '0;
      r_ms_valid <= 1'b0;
      r_overrun  <= 1'b0;
    end else begin
      r_overrun <= adc_valid && ((r_state == ST_DRAIN) || (r_state == ST_HOLD));
      r_acc     <= w_acc_next;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_state <= ST_ACCUM;
            r_busy  <= 1'b1;
            r_acc   <= '0;
            r_cnt   <= '0;
          end
        end
        ST_ACCUM: begin
          if (adc_valid) begin
            r_cnt <= r_cnt + LOG2_N'(1);
            if (&r_cnt) begin
              r_state <= ST_DRAIN;
            end
          end
        end
        // The last square lands in S2 once S1 is empty; fold it in while loading.
        ST_DRAIN: begin
          if (!w_vld_p1) begin
            r_state    <= ST_HOLD;
            r_ms_data  <= mean_floor(w_acc_next);
            r_ms_valid <= 1'b1;
          end
        end
        ST_HOLD: begin
          if (ms_ready) begin
            r_ms_valid <= 1'b0;
            if (cont) begin
              r_state <= ST_ACCUM;
              r_acc   <= '0;
              r_cnt   <= '0;
            end else begin
              r_state <= ST_IDLE;
              r_busy  <= 1'b0;
            end
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign busy     = r_busy;
  assign ms_data  = r_ms_data;
  assign ms_valid = r_ms_valid;
  assign overrun  = r_overrun;

endmodule
